mem_lsu: RTL

// - MEM-stage load/store unit; consumes EX ALU result (effective address) plus rs2 store data.
// - Issues one data-memory transaction per load/store over a req/gnt + rvalid handshake.
// - Aligns, sign/zero-extends load data for WB; stalls the pipeline while an access is outstanding.

---
 rtl/mem_lsu.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: one req/gnt + rvalid data-memory access per load/store, with WB alignment/extension.
// Optional MISALIGN_TRAP_EN: misaligned half/word accesses complete with o_misaligned instead of being forced aligned.
module mem_lsu #(
    parameter int RESP_TIMEOUT = 255,
    parameter int TMO_W        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_memRead,
    input  logic        i_memWrite,
    input  logic [2:0]  i_func3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_storeData,
    output logic        o_stall,
    output logic        o_valid,
    output logic [31:0] o_loadData,
    output logic        o_err,
    output logic        o_misaligned,
    output logic        o_dmemReq,
    input  logic        i_dmemGnt,
    output logic [31:0] o_dmemAddr,
    output logic        o_dmemWe,
    output logic [3:0]  o_dmemBe,
    output logic [31:0] o_dmemWdata,
    input  logic        i_dmemRvalid,
    input  logic [31:0] i_dmemRdata,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RESP_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       addr_q, wdata_q, data_q;
    logic [3:0]        be_q;
    logic [2:0]        func3_q;
    logic [1:0]        lane_q;
    logic              we_q, done_q, done_d, err_q, err_d;
    logic              start, illegal, load_ok, store_ok, capture, latch, tmo_hit;
    logic [1:0]        lane_new;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new, shifted, ext;
`ifdef MISALIGN_TRAP_EN
    logic              mis_q, mis_d, misalign;
`endif

    // Field decode for a new access; sub-word lanes are forced aligned by size.
    always_comb begin
        load_ok  = (i_func3 == 3'b000) || (i_func3 == 3'b001) || (i_func3 == 3'b010) ||
                   (i_func3 == 3'b100) || (i_func3 == 3'b101);
        store_ok = !i_func3[2] && (i_func3[1:0] != 2'b11);
        illegal  = (i_memRead && i_memWrite) || (i_memRead && !load_ok) ||
                   (i_memWrite && !store_ok);
        lane_new = 2'b00;
        be_new   = 4'hF;
        case (i_func3[1:0])
            2'b00:   begin lane_new = i_addr[1:0];       be_new = 4'b0001 << lane_new; end
            2'b01:   begin lane_new = {i_addr[1], 1'b0}; be_new = 4'b0011 << lane_new; end
            default: begin lane_new = 2'b00;             be_new = 4'hF;                end
        endcase
        case (i_func3[1:0])
            2'b00:   wdata_new = {4{i_storeData[7:0]}};
            2'b01:   wdata_new = {2{i_storeData[15:0]}};
            default: wdata_new = i_storeData;
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign = ((i_func3[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_func3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`endif
    end

    always_comb begin
        shifted = i_dmemRdata >> {lane_q, 3'b000};
        case (func3_q)
            3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ext = {24'd0, shifted[7:0]};
            3'b101:  ext = {16'd0, shifted[15:0]};
            default: ext = i_dmemRdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        capture = 1'b0;
        latch   = 1'b0;
        o_stall = 1'b0;
        o_valid = done_q;
`ifdef MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
        // A completion cycle blocks a new start so a held EX/MEM entry is not reissued.
        start   = (state_q == S_IDLE) && i_valid && (i_memRead || i_memWrite) && !done_q;
        tmo_hit = (RESP_TIMEOUT != 0) && (tmo_q == TMO_LAST);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    o_stall = 1'b1;
                    if (illegal) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
`ifdef MISALIGN_TRAP_EN
                    else if (misalign) begin
                        done_d = 1'b1;
                        mis_d  = 1'b1;
                    end
`endif
                    else begin
                        capture = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                o_stall = 1'b1;
                if (i_dmemGnt && we_q) begin
                    state_d = S_IDLE;
                    o_valid = 1'b1;
                    o_stall = 1'b0;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (i_dmemGnt) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                o_stall = 1'b1;
                if (i_dmemRvalid) begin
                    latch   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (tmo_hit) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        tmo_d = ((state_q == S_IDLE) || (state_d == S_IDLE)) ? '0 : tmo_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            tmo_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            be_q    <= '0;
            func3_q <= '0;
            lane_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            done_q  <= done_d;
            err_q   <= err_d;
            data_q  <= latch ? ext : 32'd0;
`ifdef MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
            if (capture) begin
                addr_q  <= {i_addr[31:2], 2'b00};
                wdata_q <= wdata_new;
                be_q    <= be_new;
                func3_q <= i_func3;
                lane_q  <= lane_new;
                we_q    <= i_memWrite;
            end
        end
    end

    assign o_dmemReq   = (state_q == S_REQ);
    assign o_dmemAddr  = addr_q;
    assign o_dmemWdata = wdata_q;
    assign o_dmemWe    = o_dmemReq && we_q;
    assign o_dmemBe    = o_dmemReq ? be_q : 4'd0;
    assign o_loadData  = data_q;
    assign o_err       = err_q;
    assign dbg_state   = state_q;
`ifdef MISALIGN_TRAP_EN
    assign o_misaligned = mis_q;
`else
    assign o_misaligned = 1'b0;
`endif
endmodule
